// File: rtl/data_mem_responder.sv
// Handshaked byte-addressed data-memory responder with programmable access latency.
// Requests are captured on accept and the access happens after LATENCY wait cycles. The
// response is then held until the requester takes it. Misaligned or illegal requests
// complete with rsp_err set and never touch storage.
module data_mem_responder #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned LATENCY       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [3:0]               req_we,
  input  logic [2:0]               req_re,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err
);

  localparam int unsigned Depth   = 2 ** ADDRESS_WIDTH;
  localparam logic [3:0]  CntLoad = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [3:0]               we_q;
  logic [2:0]               re_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic                     err_q;

  logic [7:0]               mem_q [Depth];

  logic                     accept;
  logic                     access;
  logic [ADDRESS_WIDTH-1:0] acc_addr;
  logic [3:0]               acc_we;
  logic [2:0]               acc_re;
  logic [DATA_WIDTH-1:0]    acc_wdata;
  logic                     is_store;
  logic                     acc_err;
  logic [ADDRESS_WIDTH-1:0] lane_addr [4];
  logic [31:0]              load_word;
  logic [31:0]              load_data;
  logic [DATA_WIDTH-1:0]    rdata_d;

  assign req_ready = (state_q == StIdle) && rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // With zero latency the access happens on the accept edge, so it must use the live inputs.
  always_comb begin
    if (state_q == StIdle) begin
      acc_addr  = req_addr;
      acc_we    = req_we;
      acc_re    = req_re;
      acc_wdata = req_wdata;
    end else begin
      acc_addr  = addr_q;
      acc_we    = we_q;
      acc_re    = re_q;
      acc_wdata = wdata_q;
    end
    access = ((state_q == StIdle) && accept && (LATENCY == 0)) ||
             ((state_q == StWait) && (cnt_q == 4'd0));
  end

  // Legality and alignment checks for the request being accessed.
  always_comb begin
    is_store = |acc_we;
    acc_err  = 1'b0;
    if (is_store) begin
      case (acc_we)
        4'b0001: acc_err = 1'b0;
        4'b0011: acc_err = acc_addr[0];
        4'b1111: acc_err = |acc_addr[1:0];
        default: acc_err = 1'b1;
      endcase
    end else begin
      case (acc_re)
        3'b000, 3'b100: acc_err = 1'b0;
        3'b001, 3'b101: acc_err = acc_addr[0];
        3'b010:         acc_err = |acc_addr[1:0];
        default:        acc_err = 1'b1;
      endcase
    end
  end

  // Little-endian lane gather and load extension; addresses wrap within storage.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_addr[k] = acc_addr + ADDRESS_WIDTH'(k);
    end
    load_word = {mem_q[lane_addr[3]], mem_q[lane_addr[2]],
                 mem_q[lane_addr[1]], mem_q[lane_addr[0]]};
    case (acc_re)
      3'b000:  load_data = {{24{load_word[7]}}, load_word[7:0]};
      3'b001:  load_data = {{16{load_word[15]}}, load_word[15:0]};
      3'b010:  load_data = load_word;
      3'b100:  load_data = {24'b0, load_word[7:0]};
      3'b101:  load_data = {16'b0, load_word[15:0]};
      default: load_data = '0;
    endcase
    rdata_d = (is_store || acc_err) ? '0 : load_data;
  end

  // Next-state logic for the request lifecycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntLoad;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, request capture and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      we_q    <= 4'd0;
      re_q    <= 3'd0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= req_addr;
        we_q    <= req_we;
        re_q    <= req_re;
        wdata_q <= req_wdata;
      end
      if (access) begin
        rdata_q <= rdata_d;
        err_q   <= acc_err;
      end
    end
  end

  // Storage is never reset; only legal stores write their enabled lanes.
  always_ff @(posedge clk) begin
    if (access && is_store && !acc_err) begin
      for (int k = 0; k < 4; k++) begin
        if (acc_we[k]) begin
          mem_q[lane_addr[k]] <= acc_wdata[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: a LATENCY=2 instance driven through a
// scoreboard of expected responses, plus a LATENCY=0 instance for zero-wait timing.
module tb_data_mem_responder;

  localparam int Lat = 2;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic [3:0]  we;
    logic [2:0]  re;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [7:0]  req_addr = '0;
  logic [3:0]  req_we = '0;
  logic [2:0]  req_re = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        req_valid_z = 1'b0, req_ready_z;
  logic [7:0]  req_addr_z = '0;
  logic [3:0]  req_we_z = '0;
  logic [2:0]  req_re_z = '0;
  logic [31:0] req_wdata_z = '0;
  logic        rsp_valid_z, rsp_ready_z = 1'b0;
  logic [31:0] rsp_rdata_z;
  logic        rsp_err_z;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .LATENCY(Lat)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_re(req_re), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .LATENCY(0)) dut_z (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_addr(req_addr_z),
    .req_we(req_we_z), .req_re(req_re_z), .req_wdata(req_wdata_z),
    .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_rdata(rsp_rdata_z),
    .rsp_err(rsp_err_z)
  );

  // Drive one request until accepted, record its expected response; returns at the
  // falling edge right after the accept edge with the request inputs scrambled.
  task automatic send(input vec_t v);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = v.we;
    req_re    = v.re;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout got req_ready=%b exp=1", req_ready);
    end
    sb.push_back('{rdata: v.erd, err: v.eerr});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom_range(255, 0);
    req_wdata = $urandom;
    req_we    = 4'b1111;
    req_re    = 3'b111;
  endtask

  // Wait (bounded) for the response, hold it for `hold` cycles, then handshake and pop.
  task automatic recv(input int hold, output logic [31:0] rd, output logic er,
                      output int lat, output exp_t ex);
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    if (sb.size() > 0) ex = sb.pop_front();
    else ex = '{rdata: 32'hxxxxxxxx, err: 1'bx};
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset got ready=%b valid=%b rdata=%h err=%b exp 0/0/0/0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    checks++;
    if (req_ready_z !== 1'b0 || rsp_valid_z !== 1'b0 || rsp_rdata_z !== 32'h0) begin
      failures++;
      $display("FAIL reset_z got ready=%b valid=%b rdata=%h exp 0/0/0",
               req_ready_z, rsp_valid_z, rsp_rdata_z);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got ready=%b valid=%b exp 1/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_store_load;
    vec_t v [2];
    logic [31:0] rd;
    logic er;
    int lat;
    exp_t ex;
    v[0] = '{4'b1111, 3'b000, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0};
    v[1] = '{4'b0000, 3'b010, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0};
    for (int i = 0; i < 2; i++) begin
      send(v[i]);
      recv(0, rd, er, lat, ex);
      checks += 3;
      if (lat !== Lat) begin
        failures++;
        $display("FAIL store_load[%0d] latency got=%0d exp=%0d", i, lat, Lat);
      end
      if (rd !== ex.rdata) begin
        failures++;
        $display("FAIL store_load[%0d] rdata got=%h exp=%h", i, rd, ex.rdata);
      end
      if (er !== ex.err) begin
        failures++;
        $display("FAIL store_load[%0d] err got=%b exp=%b", i, er, ex.err);
      end
    end
  endtask

  task automatic test_sized_loads;
    vec_t v [4];
    logic [31:0] rd;
    logic er;
    int lat;
    exp_t ex;
    v[0] = '{4'b0000, 3'b000, 8'h13, 32'h0, 32'hFFFFFFDE, 1'b0};
    v[1] = '{4'b0000, 3'b100, 8'h13, 32'h0, 32'h000000DE, 1'b0};
    v[2] = '{4'b0000, 3'b001, 8'h12, 32'h0, 32'hFFFFDEAD, 1'b0};
    v[3] = '{4'b0000, 3'b101, 8'h10, 32'h0, 32'h0000BEEF, 1'b0};
    for (int i = 0; i < 4; i++) begin
      send(v[i]);
      recv(0, rd, er, lat, ex);
      checks += 2;
      if (rd !== ex.rdata) begin
        failures++;
        $display("FAIL sized_load[%0d] rdata got=%h exp=%h", i, rd, ex.rdata);
      end
      if (er !== ex.err) begin
        failures++;
        $display("FAIL sized_load[%0d] err got=%b exp=%b", i, er, ex.err);
      end
    end
  endtask

  task automatic test_byte_lanes;
    vec_t v [4];
    logic [31:0] rd;
    logic er;
    int lat;
    exp_t ex;
    v[0] = '{4'b0001, 3'b000, 8'h11, 32'h00000055, 32'h0, 1'b0};
    v[1] = '{4'b0000, 3'b010, 8'h10, 32'h0, 32'hDEAD55EF, 1'b0};
    v[2] = '{4'b0011, 3'b000, 8'h12, 32'h00001234, 32'h0, 1'b0};
    v[3] = '{4'b0000, 3'b010, 8'h10, 32'h0, 32'h123455EF, 1'b0};
    for (int i = 0; i < 4; i++) begin
      send(v[i]);
      recv(0, rd, er, lat, ex);
      checks += 2;
      if (rd !== ex.rdata) begin
        failures++;
        $display("FAIL byte_lane[%0d] rdata got=%h exp=%h", i, rd, ex.rdata);
      end
      if (er !== ex.err) begin
        failures++;
        $display("FAIL byte_lane[%0d] err got=%b exp=%b", i, er, ex.err);
      end
    end
  endtask

  task automatic test_errors;
    vec_t v [6];
    logic [31:0] rd;
    logic er;
    int lat;
    exp_t ex;
    v[0] = '{4'b0000, 3'b010, 8'h12, 32'h0, 32'h0, 1'b1};
    v[1] = '{4'b0011, 3'b000, 8'h11, 32'h0000AAAA, 32'h0, 1'b1};
    v[2] = '{4'b0000, 3'b010, 8'h10, 32'h0, 32'h123455EF, 1'b0};
    v[3] = '{4'b0101, 3'b000, 8'h10, 32'h77777777, 32'h0, 1'b1};
    v[4] = '{4'b0000, 3'b011, 8'h10, 32'h0, 32'h0, 1'b1};
    v[5] = '{4'b0000, 3'b010, 8'h10, 32'h0, 32'h123455EF, 1'b0};
    for (int i = 0; i < 6; i++) begin
      send(v[i]);
      recv(0, rd, er, lat, ex);
      checks += 3;
      if (lat !== Lat) begin
        failures++;
        $display("FAIL error[%0d] latency got=%0d exp=%0d", i, lat, Lat);
      end
      if (rd !== ex.rdata) begin
        failures++;
        $display("FAIL error[%0d] rdata got=%h exp=%h", i, rd, ex.rdata);
      end
      if (er !== ex.err) begin
        failures++;
        $display("FAIL error[%0d] err got=%b exp=%b", i, er, ex.err);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd0, rd;
    logic er0, er;
    int lat;
    exp_t ex;
    send('{4'b0000, 3'b010, 8'h10, 32'h0, 32'h123455EF, 1'b0});
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rd0 = rsp_rdata;
    er0 = rsp_err;
    // A competing request waits while the response is stalled.
    req_valid = 1'b1;
    req_we    = 4'b0000;
    req_re    = 3'b000;
    req_addr  = 8'h13;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd0 || rsp_err !== er0 || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall[%0d] got valid=%b rdata=%h err=%b ready=%b exp 1/%h/%b/0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready, rd0, er0);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    ex = sb.pop_front();
    checks += 3;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL handshake_ready got=%b exp=0", req_ready);
    end
    if (rd0 !== ex.rdata || er0 !== ex.err) begin
      failures++;
      $display("FAIL stall_data got=%h/%b exp=%h/%b", rd0, er0, ex.rdata, ex.err);
    end
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL after_handshake got ready=%b valid=%b exp 1/0", req_ready, rsp_valid);
    end
    sb.push_back('{rdata: 32'h00000012, err: 1'b0});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    recv(0, rd, er, lat, ex);
    checks += 2;
    if (lat !== Lat) begin
      failures++;
      $display("FAIL queued_req latency got=%0d exp=%0d", lat, Lat);
    end
    if (rd !== ex.rdata || er !== ex.err) begin
      failures++;
      $display("FAIL queued_req got=%h/%b exp=%h/%b", rd, er, ex.rdata, ex.err);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    logic er;
    int lat;
    exp_t ex;
    send('{4'b1111, 3'b000, 8'h20, 32'h11223344, 32'h0, 1'b0});
    recv(0, rd, er, lat, ex);
    send('{4'b0000, 3'b010, 8'h20, 32'h0, 32'h11223344, 1'b0});
    recv(0, rd, er, lat, ex);
    checks++;
    if (rd !== ex.rdata) begin
      failures++;
      $display("FAIL pre_reset_load got=%h exp=%h", rd, ex.rdata);
    end
    send('{4'b1111, 3'b000, 8'h20, 32'hCAFEF00D, 32'h0, 1'b0});
    ex = sb.pop_back();
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got ready=%b valid=%b rdata=%h err=%b exp 0/0/0/0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset got valid=%b ready=%b exp 0/1", rsp_valid, req_ready);
    end
    send('{4'b0000, 3'b010, 8'h20, 32'h0, 32'h11223344, 1'b0});
    recv(0, rd, er, lat, ex);
    checks++;
    if (rd !== ex.rdata || er !== ex.err) begin
      failures++;
      $display("FAIL dropped_store got=%h/%b exp=%h/%b", rd, er, ex.rdata, ex.err);
    end
  endtask

  task automatic test_zero_latency;
    vec_t v [2];
    v[0] = '{4'b1111, 3'b000, 8'h40, 32'hA5A55A5A, 32'h0, 1'b0};
    v[1] = '{4'b0000, 3'b010, 8'h40, 32'h0, 32'hA5A55A5A, 1'b0};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req_valid_z = 1'b1;
      req_we_z    = v[i].we;
      req_re_z    = v[i].re;
      req_addr_z  = v[i].addr;
      req_wdata_z = v[i].wdata;
      checks++;
      if (req_ready_z !== 1'b1) begin
        failures++;
        $display("FAIL zlat[%0d] ready got=%b exp=1", i, req_ready_z);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid_z = 1'b0;
      req_we_z    = 4'b1111;
      req_wdata_z = 32'h0;
      checks++;
      if (rsp_valid_z !== 1'b1 || rsp_rdata_z !== v[i].erd || rsp_err_z !== v[i].eerr) begin
        failures++;
        $display("FAIL zlat[%0d] rsp got valid=%b rdata=%h err=%b exp 1/%h/%b",
                 i, rsp_valid_z, rsp_rdata_z, rsp_err_z, v[i].erd, v[i].eerr);
      end
      rsp_ready_z = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready_z = 1'b0;
      checks++;
      if (rsp_valid_z !== 1'b0 || req_ready_z !== 1'b1) begin
        failures++;
        $display("FAIL zlat[%0d] return got valid=%b ready=%b exp 0/1",
                 i, rsp_valid_z, req_ready_z);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    test_reset();
    test_store_load();
    test_sized_loads();
    test_byte_lanes();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_zero_latency();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
